iob_vexriscv_bus_arb: RTL
=========================

// Module: iob_vexriscv_bus_arb
// PURPOSE
//  Merges the VexRiscv wrapper's instruction bus and data bus (IOb native req/resp) into one
//  IOb native port toward the internal SRAM/DDR interconnect. Sits directly downstream of the
//  core wrapper. Allows one outstanding transaction at a time and routes each response back
//  to the master that issued the request.
// PARAMETERS
//  ADDR_W  32  address width; REQ_W=1+ADDR_W+DATA_W+DATA_W/8
//  DATA_W  32  data width; RESP_W=DATA_W+2
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-low
//  ibus_req   in   REQ_W   {valid,addr,wdata,wstrb} from ibus master (m0); wstrb always 0
//  ibus_resp  out  RESP_W  {rdata,rvalid,ready} to m0
//  dbus_req   in   REQ_W   {valid,addr,wdata,wstrb} from dbus master (m1)
//  dbus_resp  out  RESP_W  {rdata,rvalid,ready} to m1
//  mem_req    out  REQ_W   merged request to interconnect
//  mem_resp   in   RESP_W  {rdata,rvalid,ready} from interconnect
//  busy       out  1       high when state != IDLE
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=IDLE, grant=m0, last=m0. mem_req=0. ibus_resp=0. dbus_resp=0. busy=0.
//    In-flight transaction is abandoned. A late mem_resp rvalid arriving after reset is ignored.
//  - Masters hold valid/addr/wdata/wstrb stable until they see ready.
//    A read is wstrb==0. A write is wstrb!=0.
//  - FSM IDLE->REQ->(WAIT_RD)->IDLE. The state, grant and last registers are all registered.
//  - IDLE: if any valid, register the grant and go to REQ. If no valid, stay in IDLE.
//    Request latency is +1 cycle versus a direct connection.
//  - REQ: mem_req = the granted master's req, passed through combinationally.
//    Granted master's ready = mem_resp.ready. Non-granted master's ready = 0.
//    On mem_resp.ready: a write goes to IDLE; a read goes to WAIT_RD. last<=grant.
//    If the granted master's valid drops before ready (protocol violation), go to IDLE;
//    this is flagged by an assertion in simulation.
//  - WAIT_RD: mem_req.valid=0. When mem_resp.rvalid=1, drive it to the granted master as
//    rvalid=1, rdata=mem_resp.rdata for exactly that cycle, then go to IDLE.
//    The other master's rvalid stays 0.
//  - mem_resp.rvalid in IDLE/REQ is ignored (interconnect guarantees rvalid >=1 cycle after ready).
//  - rdata is forwarded only to the granted master; the other master sees rdata=0.
//  - Simultaneous valid in IDLE: resolved per CONFIGURATION. A new request can be granted in the
//    IDLE cycle that follows a completion; there are no back-to-back grants without IDLE.
//  - Throughput: write >= 2 cycles; read >= 3 cycles.
// CONFIGURATION
//  - IOB_BUS_ARB_RR_EN defined: round-robin. On conflict, grant the master != last.
//  - Not defined: fixed priority. On conflict, dbus (m1) always wins; last is unused.
//  - A single-master request is granted immediately in both modes.
// STRUCTURE
//  - iob_lib.vh holds shared definitions: REQ_W/RESP_W field macros (valid, address, wdata, wstrb,
//    ready, rvalid, rdata), state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT_RD=2'd2,
//    and master ids M_IBUS=1'b0, M_DBUS=1'b1.
//  - Sub-module iob_arb2_grant: combinational 2-input grant selection (inputs req[1:0], last;
//    output gnt). It contains the IOB_BUS_ARB_RR_EN logic. The top level contains the FSM,
//    registers and muxes.
// TESTING
//  1 rst=0 mid WAIT_RD, then rst=1; mem rvalid=1 next cycle -> no master sees rvalid; state IDLE;
//    all outputs 0 during reset.
//  2 ibus read addr 0x100, mem ready after 2 cycles, rvalid 1 cycle later with rdata 0xDEADBEEF
//    -> ibus ready=1 exactly once; ibus rvalid=1 once with 0xDEADBEEF; dbus_resp stays 0.
//  3 dbus write addr 0x2004 wdata 0x12345678 wstrb 4'hC, mem ready immediately -> mem_req matches
//    bit-exact; dbus ready=1; no rvalid; back in IDLE 2 cycles after grant.
//  4 both valid every cycle, 4 reads each, RR_EN -> grants alternate starting with dbus;
//    without RR_EN -> all 4 dbus reads complete before the first ibus grant.
//  5 mem ready held 0 for 20 cycles -> granted master's req held on mem_req; busy=1;
//    other master's ready=0 throughout.
//  6 spurious mem rvalid=1 in IDLE with rdata 0xFFFF0000 -> ignored; no master rvalid; state unchanged.

Source files
------------

// File: rtl/iob_vexriscv_bus_arb_pkg.sv
// rtl/iob_vexriscv_bus_arb_pkg.sv - shared types and field positions for the VexRiscv bus arbiter
//
// Purpose: FSM state encoding, master ids and IOb response bit positions used by
//          iob_vexriscv_bus_arb and its grant sub-module.
//          Request layout  : {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
//          Response layout : {rdata[DATA_W], rvalid, ready}
// Ports:   none (package)

package iob_vexriscv_bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT_RD = 2'd2
   } arb_state_e;

   localparam logic M_IBUS = 1'b0;
   localparam logic M_DBUS = 1'b1;

   localparam int RSP_READY_BIT  = 0;
   localparam int RSP_RVALID_BIT = 1;
   localparam int RSP_RDATA_LSB  = 2;

endpackage

// File: rtl/iob_vexriscv_bus_arb_grant.sv
// rtl/iob_vexriscv_bus_arb_grant.sv - combinational two-master grant selection
//
// Purpose: picks which master wins when the arbiter is idle.
//          IOB_BUS_ARB_RR_EN defined : on conflict grant the master that did not finish last.
//          IOB_BUS_ARB_RR_EN undefined: on conflict the dbus master (m1) always wins.
//          A lone requester is granted in both modes.
// Ports:   req_i[1:0]  in   {dbus valid, ibus valid}
//          last_i      in   master id of the last completed transaction
//          gnt_o       out  granted master id (only meaningful when req_i != 0)

module iob_vexriscv_bus_arb_grant
   import iob_vexriscv_bus_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_o
);

   always_comb begin
      gnt_o = M_IBUS;
      case (req_i)
         2'b01:   gnt_o = M_IBUS;
         2'b10:   gnt_o = M_DBUS;
`ifdef IOB_BUS_ARB_RR_EN
         2'b11:   gnt_o = ~last_i;
`else
         2'b11:   gnt_o = M_DBUS;
`endif
         default: gnt_o = M_IBUS;
      endcase
   end

`ifndef IOB_BUS_ARB_RR_EN
   // Fixed priority never looks at history.
   logic unused_last;
   assign unused_last = last_i;
`endif

endmodule

// File: rtl/iob_vexriscv_bus_arb.sv
// rtl/iob_vexriscv_bus_arb.sv - merges VexRiscv ibus and dbus onto one IOb native port
//
// Purpose: one outstanding transaction at a time. IDLE registers a grant, REQ passes the
//          granted request through to memory, WAIT_RD waits for read data and returns it to
//          the master that issued the read. Conflict policy lives in the grant sub-module and
//          is selected by the IOB_BUS_ARB_RR_EN macro (round-robin when defined, dbus
//          priority otherwise).
// Ports:   clk_i         in   clock
//          rst_i         in   synchronous active-low reset
//          ibus_req_i    in   REQ_W  {valid,addr,wdata,wstrb} from ibus master (m0)
//          ibus_resp_o   out  RESP_W {rdata,rvalid,ready} to m0
//          dbus_req_i    in   REQ_W  {valid,addr,wdata,wstrb} from dbus master (m1)
//          dbus_resp_o   out  RESP_W {rdata,rvalid,ready} to m1
//          mem_req_o     out  REQ_W  merged request to the interconnect
//          mem_resp_i    in   RESP_W {rdata,rvalid,ready} from the interconnect
//          busy_o        out  high whenever the FSM is not IDLE

module iob_vexriscv_bus_arb
   import iob_vexriscv_bus_arb_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
   localparam int RESP_W = DATA_W + 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REQ_W-1:0]  ibus_req_i,
   output logic [RESP_W-1:0] ibus_resp_o,
   input  logic [REQ_W-1:0]  dbus_req_i,
   output logic [RESP_W-1:0] dbus_resp_o,
   output logic [REQ_W-1:0]  mem_req_o,
   input  logic [RESP_W-1:0] mem_resp_i,
   output logic              busy_o
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q,  last_d;

   logic [1:0]        req_vec;
   logic              gnt_sel;
   logic [REQ_W-1:0]  gnt_req;
   logic              gnt_valid;
   logic              gnt_is_write;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [RESP_W-1:0] resp_sel;

   assign req_vec      = {dbus_req_i[REQ_W-1], ibus_req_i[REQ_W-1]};
   assign gnt_req      = (grant_q == M_DBUS) ? dbus_req_i : ibus_req_i;
   assign gnt_valid    = gnt_req[REQ_W-1];
   assign gnt_is_write = |gnt_req[STRB_W-1:0];
   assign mem_ready    = mem_resp_i[RSP_READY_BIT];
   assign mem_rvalid   = mem_resp_i[RSP_RVALID_BIT];
   assign mem_rdata    = mem_resp_i[RESP_W-1:RSP_RDATA_LSB];

   iob_vexriscv_bus_arb_grant u_grant (
      .req_i  (req_vec),
      .last_i (last_q),
      .gnt_o  (gnt_sel)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_vec) begin
               grant_d = gnt_sel;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // A master dropping valid before ready is a protocol error; recover to IDLE.
            if (!gnt_valid) begin
               state_d = ST_IDLE;
            end else if (mem_ready) begin
               last_d  = grant_q;
               state_d = gnt_is_write ? ST_IDLE : ST_WAIT_RD;
            end
         end
         ST_WAIT_RD: begin
            if (mem_rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= M_IBUS;
         last_q  <= M_IBUS;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Outputs are forced to zero while reset is asserted so nothing leaks out of a
   // transaction that reset is abandoning, even before the reset edge lands.
   always_comb begin
      mem_req_o   = '0;
      ibus_resp_o = '0;
      dbus_resp_o = '0;
      resp_sel    = '0;
      if (rst_i) begin
         case (state_q)
            ST_REQ: begin
               mem_req_o = gnt_req;
               resp_sel  = {{DATA_W{1'b0}}, 1'b0, mem_ready};
            end
            ST_WAIT_RD: begin
               if (mem_rvalid) begin
                  resp_sel = {mem_rdata, 1'b1, 1'b0};
               end
            end
            default: resp_sel = '0;
         endcase
      end
      if (grant_q == M_DBUS) begin
         dbus_resp_o = resp_sel;
      end else begin
         ibus_resp_o = resp_sel;
      end
   end

   assign busy_o = rst_i && (state_q != ST_IDLE);

`ifndef SYNTHESIS
   // The granted master must keep valid asserted until it has been given ready.
   a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_i)
      (state_q == ST_REQ) |-> gnt_valid);
`endif

endmodule
